ladybird_boot_loader: RTL and testbench

- Hardware program loader. Receives a framed byte stream from a UART receiver and writes it word by word into instruction RAM over a ladybird_bus master port.
- Holds the core in reset while loading. Releases the core only after the whole image arrives with a correct checksum.
- Sits between the serial receiver and the instruction-bus arbitrator, as an input alongside the core ibus.
- Generalised in data width, base address, image depth, frame magic and inter-byte timeout.

---
 rtl/ladybird_boot_loader.sv | 212 +++++++++++++++++++++
 tb/tb_ladybird_boot_loader.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ladybird_boot_loader.sv
// rtl/ladybird_boot_loader.sv - framed UART image loader writing instruction RAM over ladybird_bus
module ladybird_boot_loader #(
  parameter int unsigned       XLEN      = 32,
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int unsigned       MAX_WORDS = 1024,
  parameter logic [7:0]        MAGIC     = 8'hA5,
  parameter int unsigned       TIMEOUT   = 100000
) (
  input  logic              clk,
  input  logic              anrst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              bus_req,
  input  logic              bus_gnt,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [XLEN/8-1:0] bus_wstrb,
  output logic [XLEN-1:0]   bus_wdata,
  input  logic              reload,
  output logic              core_nrst,
  output logic              done,
  output logic              error,
  output logic [15:0]       words_written
);

  localparam int unsigned BPW = XLEN / 8;
  localparam int unsigned BIW = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int unsigned CW  = $clog2(TIMEOUT + 1);
  localparam logic [BIW-1:0] LAST_BYTE = BIW'(BPW - 1);
  localparam logic [CW-1:0]  TO_LAST   = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN0, S_LEN1, S_DATA, S_WRITE, S_CSUM, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [XLEN-1:0]   word_q, word_d;
  logic [BIW-1:0]    byte_idx_q, byte_idx_d;
  logic [7:0]        csum_q, csum_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              bus_req_q, bus_req_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [BPW-1:0]    bus_wstrb_q, bus_wstrb_d;
  logic [XLEN-1:0]   bus_wdata_q, bus_wdata_d;
  logic              core_nrst_q, core_nrst_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic [15:0]       ww_q, ww_d;

  logic              accept;
  logic              counting;
  logic [XLEN-1:0]   word_next;
  logic [15:0]       n_words;

  assign rx_ready      = (state_q != S_WRITE) && (state_q != S_DONE);
  assign bus_req       = bus_req_q;
  assign bus_addr      = bus_addr_q;
  assign bus_wstrb     = bus_wstrb_q;
  assign bus_wdata     = bus_wdata_q;
  assign core_nrst     = core_nrst_q;
  assign done          = done_q;
  assign error         = error_q;
  assign words_written = ww_q;

  // Next-state logic: reload beats timeout, timeout beats byte acceptance
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    word_d      = word_q;
    byte_idx_d  = byte_idx_q;
    csum_d      = csum_q;
    bus_req_d   = bus_req_q;
    bus_addr_d  = bus_addr_q;
    bus_wstrb_d = bus_wstrb_q;
    bus_wdata_d = bus_wdata_q;
    core_nrst_d = core_nrst_q;
    done_d      = done_q;
    error_d     = error_q;
    ww_d        = ww_q;

    accept   = rx_valid && rx_ready;
    counting = (state_q == S_LEN0) || (state_q == S_LEN1) ||
               (state_q == S_DATA) || (state_q == S_CSUM);
    n_words  = {rx_data, len_q[7:0]};

    word_next = word_q;
    for (int b = 0; b < BPW; b++) begin
      if (byte_idx_q == BIW'(b)) word_next[b*8 +: 8] = rx_data;
    end

    if (!counting)   cnt_d = '0;
    else if (accept) cnt_d = '0;
    else             cnt_d = cnt_q + CW'(1);

    if (reload) begin
      state_d     = S_IDLE;
      bus_req_d   = 1'b0;
      core_nrst_d = 1'b0;
      done_d      = 1'b0;
      cnt_d       = '0;
    end else if (counting && (cnt_q == TO_LAST)) begin
      error_d = 1'b1;
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept && (rx_data == MAGIC)) begin
            error_d    = 1'b0;
            ww_d       = '0;
            csum_d     = '0;
            byte_idx_d = '0;
            state_d    = S_LEN0;
          end
        end
        S_LEN0: begin
          if (accept) begin
            len_d[7:0] = rx_data;
            state_d    = S_LEN1;
          end
        end
        S_LEN1: begin
          if (accept) begin
            len_d = n_words;
            if (32'(n_words) > 32'(MAX_WORDS)) begin
              error_d = 1'b1;
              state_d = S_IDLE;
            end else if (n_words == 16'd0) begin
              state_d = S_CSUM;
            end else begin
              state_d = S_DATA;
            end
          end
        end
        S_DATA: begin
          if (accept) begin
            csum_d = csum_q + rx_data;
            word_d = word_next;
            if (byte_idx_q == LAST_BYTE) begin
              byte_idx_d  = '0;
              state_d     = S_WRITE;
              bus_req_d   = 1'b1;
              bus_addr_d  = BASE_ADDR + ADDR_W'(ww_q) * ADDR_W'(BPW);
              bus_wstrb_d = '1;
              bus_wdata_d = word_next;
            end else begin
              byte_idx_d = byte_idx_q + BIW'(1);
            end
          end
        end
        S_WRITE: begin
          if (bus_req_q && bus_gnt) begin
            bus_req_d = 1'b0;
            ww_d      = ww_q + 16'd1;
            state_d   = ((ww_q + 16'd1) == len_q) ? S_CSUM : S_DATA;
          end
        end
        S_CSUM: begin
          if (accept) begin
            if (rx_data == csum_q) begin
              state_d     = S_DONE;
              core_nrst_d = 1'b1;
              done_d      = 1'b1;
            end else begin
              error_d = 1'b1;
              state_d = S_IDLE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge anrst) begin
    if (!anrst) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      word_q      <= '0;
      byte_idx_q  <= '0;
      csum_q      <= '0;
      cnt_q       <= '0;
      bus_req_q   <= 1'b0;
      bus_addr_q  <= '0;
      bus_wstrb_q <= '0;
      bus_wdata_q <= '0;
      core_nrst_q <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      ww_q        <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      word_q      <= word_d;
      byte_idx_q  <= byte_idx_d;
      csum_q      <= csum_d;
      cnt_q       <= cnt_d;
      bus_req_q   <= bus_req_d;
      bus_addr_q  <= bus_addr_d;
      bus_wstrb_q <= bus_wstrb_d;
      bus_wdata_q <= bus_wdata_d;
      core_nrst_q <= core_nrst_d;
      done_q      <= done_d;
      error_q     <= error_d;
      ww_q        <= ww_d;
    end
  end

endmodule

// File: tb/tb_ladybird_boot_loader.sv
// tb/tb_ladybird_boot_loader.sv - randomized self-checking bench for ladybird_boot_loader
module tb_ladybird_boot_loader;

  localparam int          TIMEOUT = 50;
  localparam logic [31:0] BASE    = 32'h0000_0000;

  logic        clk;
  logic        anrst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        bus_req;
  logic        bus_gnt;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic        reload;
  logic        core_nrst;
  logic        done;
  logic        error;
  logic [15:0] words_written;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_words[$];
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  logic [3:0]  wr_strb[$];
  int          gnt_delay = 0;
  bit          saw_req = 0;

  ladybird_boot_loader #(
    .XLEN(32), .ADDR_W(32), .BASE_ADDR(BASE), .MAX_WORDS(1024),
    .MAGIC(8'hA5), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .anrst(anrst), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .bus_req(bus_req), .bus_gnt(bus_gnt),
    .bus_addr(bus_addr), .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
    .reload(reload), .core_nrst(core_nrst), .done(done), .error(error),
    .words_written(words_written)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Bus slave: grants after gnt_delay cycles, records each committed write, checks hold stability
  initial begin : slave
    logic [31:0] hold_addr, hold_data;
    bit in_req;
    int wait_n;
    in_req = 0;
    wait_n = 0;
    hold_addr = '0;
    hold_data = '0;
    bus_gnt = 1'b0;
    forever begin
      @(negedge clk);
      if (anrst && bus_req) begin
        saw_req = 1;
        if (!in_req) begin
          in_req = 1;
          wait_n = 0;
          hold_addr = bus_addr;
          hold_data = bus_wdata;
        end else begin
          check("addr_stable", bus_addr, hold_addr);
          check("data_stable", bus_wdata, hold_data);
        end
        check("rx_ready_in_write", rx_ready, 0);
        if (wait_n >= gnt_delay) begin
          if (!bus_gnt) begin
            wr_addr.push_back(bus_addr);
            wr_data.push_back(bus_wdata);
            wr_strb.push_back(bus_wstrb);
          end
          bus_gnt = 1'b1;
        end else begin
          wait_n++;
          bus_gnt = 1'b0;
        end
      end else begin
        in_req = 0;
        bus_gnt = 1'b0;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int w;
    w = 0;
    @(negedge clk);
    rx_data = b;
    rx_valid = 1'b1;
    while (!rx_ready && w < 400) begin
      @(negedge clk);
      w++;
    end
    if (w >= 400) check("rx_accept_bound", 0, 1);
    else begin
      @(posedge clk);
      #1;
    end
    rx_valid = 1'b0;
  endtask

  task automatic do_reload();
    @(negedge clk);
    reload = 1'b1;
    @(posedge clk);
    #1;
    reload = 1'b0;
    check("reload_core_nrst", core_nrst, 0);
    check("reload_done", done, 0);
  endtask

  // Reference model: frame bytes, checksum and expected write list derived from exp_words
  task automatic run_frame(input bit bad);
    logic [7:0]  bytes[$];
    logic [7:0]  sum;
    logic [15:0] n;
    logic [31:0] w;
    n = 16'(exp_words.size());
    sum = 8'h00;
    bytes.push_back(8'hA5);
    bytes.push_back(n[7:0]);
    bytes.push_back(n[15:8]);
    for (int i = 0; i < exp_words.size(); i++) begin
      w = exp_words[i];
      for (int b = 0; b < 4; b++) begin
        bytes.push_back(w[b*8 +: 8]);
        sum = sum + w[b*8 +: 8];
      end
    end
    bytes.push_back(bad ? sum + 8'd1 : sum);
    wr_addr.delete();
    wr_data.delete();
    wr_strb.delete();
    foreach (bytes[i]) begin
      send_byte(bytes[i]);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    check("frame_done", done, !bad);
    check("frame_core_nrst", core_nrst, !bad);
    check("frame_error", error, bad);
    check("frame_words_written", words_written, n);
    check("frame_write_count", wr_addr.size(), n);
    for (int i = 0; i < exp_words.size() && i < wr_addr.size(); i++) begin
      check("write_addr", wr_addr[i], BASE + 32'(4 * i));
      check("write_data", wr_data[i], exp_words[i]);
      check("write_strb", wr_strb[i], 4'hF);
    end
  endtask

  initial begin
    anrst = 1'b0;
    rx_data = 8'h00;
    rx_valid = 1'b0;
    reload = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_bus_req", bus_req, 0);
    check("rst_bus_addr", bus_addr, 0);
    check("rst_bus_wstrb", bus_wstrb, 0);
    check("rst_bus_wdata", bus_wdata, 0);
    check("rst_core_nrst", core_nrst, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_words_written", words_written, 0);
    check("rst_rx_ready", rx_ready, 1);
    anrst = 1'b1;

    // Clean load of the reference two-word image
    exp_words = '{32'h0010_0013, 32'h0000_0093};
    gnt_delay = 0;
    run_frame(0);
    do_reload();

    // Same image with a slow grant
    gnt_delay = 5;
    run_frame(0);
    do_reload();

    // Bad checksum, then a fresh magic clears the sticky error
    gnt_delay = 0;
    run_frame(1);
    send_byte(8'hA5);
    check("magic_clears_error", error, 0);
    do_reload();

    // Junk before magic, then an oversize count
    saw_req = 0;
    send_byte(8'h00);
    send_byte(8'hFF);
    check("junk_error", error, 0);
    check("junk_rx_ready", rx_ready, 1);
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h04);
    check("oversize_error", error, 1);
    repeat (3) @(negedge clk);
    check("oversize_no_req", saw_req, 0);
    check("oversize_idle", rx_ready, 1);

    // Empty image goes straight to the checksum byte
    exp_words.delete();
    run_frame(0);
    do_reload();

    // Inter-byte timeout mid-word
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h11);
    send_byte(8'h22);
    repeat (TIMEOUT - 5) @(negedge clk);
    check("timeout_not_yet", error, 0);
    repeat (8) @(negedge clk);
    check("timeout_error", error, 1);
    check("timeout_idle", rx_ready, 1);
    check("timeout_words", words_written, 0);
    exp_words = '{32'hDEAD_BEEF};
    run_frame(0);
    do_reload();

    // Randomized frames
    for (int f = 0; f < 8; f++) begin
      exp_words.delete();
      for (int i = 0; i < $urandom_range(1, 8); i++) exp_words.push_back($urandom);
      gnt_delay = $urandom_range(0, 3);
      run_frame($urandom_range(0, 3) == 0);
      do_reload();
    end

    // Asynchronous reset while a write is pending
    gnt_delay = 30;
    wr_addr.delete();
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h44);
    send_byte(8'h33);
    send_byte(8'h22);
    send_byte(8'h11);
    check("write_pending", bus_req, 1);
    @(negedge clk);
    #2 anrst = 1'b0;
    #1;
    check("arst_bus_req", bus_req, 0);
    check("arst_bus_addr", bus_addr, 0);
    check("arst_bus_wdata", bus_wdata, 0);
    check("arst_bus_wstrb", bus_wstrb, 0);
    check("arst_words", words_written, 0);
    check("arst_core_nrst", core_nrst, 0);
    repeat (2) @(negedge clk);
    anrst = 1'b1;
    check("arst_no_commit", wr_addr.size(), 0);
    gnt_delay = 1;
    exp_words = '{$urandom, $urandom, $urandom};
    run_frame(0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
